led_randomiser_array: RTL and testbench

- Multi-channel successor to the single-LED randomiser.
- Drives NUM_LEDS LEDs, each lit with its own run-time probability of 1/p per draw.
- A shared Galois LFSR and a single modulo unit are time-multiplexed round-robin across channels, one channel per clock, once per draw tick.
- Lit LEDs are held for HOLD_TICKS ticks. Sits between the board tick generator and the LEDR pins.

---
 rtl/led_randomiser_array.sv | 163 ++++++++++++++++
 tb/tb_led_randomiser_array.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_randomiser_array.sv
// led_randomiser_array: drives NUM_LEDS LEDs, each lit with a per-channel
// probability of 1/p on every draw tick. One shared Galois LFSR and one
// modulo unit are time-shared round-robin, one channel per clock.
// Optional hit statistics counter: define LED_RANDOMISER_STATS_EN.
module led_randomiser_array #(
    parameter int                    NUM_LEDS   = 10,
    parameter int                    PROB_WIDTH = 7,
    parameter int                    LFSR_WIDTH = 16,
    parameter logic [LFSR_WIDTH-1:0] SEED       = 'h0001,
    parameter int                    HOLD_TICKS = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           tick,
    input  logic [NUM_LEDS*PROB_WIDTH-1:0] probability,
`ifdef LED_RANDOMISER_STATS_EN
    input  logic                           stats_clr,
    output logic [15:0]                    hit_count,
`endif
    output logic [NUM_LEDS-1:0]            led,
    output logic                           busy
);

    localparam int CH_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [CH_W-1:0]       LAST_CH     = CH_W'(NUM_LEDS - 1);
    localparam logic [HOLD_W-1:0]     HOLD_RELOAD = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [LFSR_WIDTH-1:0] TAPS        = LFSR_WIDTH'(32'h0000_B400);
    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [LFSR_WIDTH-1:0] SEED_INIT   = (SEED == '0) ? LFSR_WIDTH'(1) : SEED;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [CH_W-1:0]         ch_idx, ch_nxt;
    logic                    scan_en;

    logic [LFSR_WIDTH-1:0]   lfsr;
    logic [HOLD_W-1:0]       hold [NUM_LEDS];
    logic [PROB_WIDTH-1:0]   prob_arr [NUM_LEDS];
    logic [PROB_WIDTH-1:0]   prob_c;
    logic [HOLD_W-1:0]       hold_c;
    logic                    draw_hit;

    // Right-shifting Galois LFSR: feed the dropped bit back through the taps.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] v);
        lfsr_step = v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEDS; gi++) begin : g_prob
            assign prob_arr[gi] = probability[gi*PROB_WIDTH +: PROB_WIDTH];
        end
    endgenerate

    // FSM state and channel index register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ch_idx <= '0;
        end else begin
            state  <= state_nxt;
            ch_idx <= ch_nxt;
        end
    end

    // Next-state logic: enable low aborts any scan; ticks during a scan are ignored.
    always_comb begin
        state_nxt = state;
        ch_nxt    = ch_idx;
        scan_en   = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            ch_nxt    = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        state_nxt = SCAN;
                        ch_nxt    = '0;
                    end
                end
                SCAN: begin
                    scan_en = 1'b1;
                    if (ch_idx == LAST_CH) begin
                        state_nxt = IDLE;
                        ch_nxt    = '0;
                    end else begin
                        ch_nxt = ch_idx + CH_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    ch_nxt    = '0;
                end
            endcase
        end
    end

    assign busy = (state == SCAN);

    // Draw for the channel under evaluation: success when p != 0 and r mod p == 0.
    always_comb begin
        prob_c   = prob_arr[ch_idx];
        hold_c   = hold[ch_idx];
        draw_hit = 1'b0;
        if (prob_c != '0) begin
            draw_hit = ((lfsr % LFSR_WIDTH'(prob_c)) == '0);
        end
    end

    // LED, hold counter and LFSR update; the LFSR only advances during a scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED_INIT;
            led  <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                hold[i] <= '0;
            end
        end else if (!enable) begin
            led <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                hold[i] <= '0;
            end
        end else if (scan_en) begin
            lfsr <= lfsr_step(lfsr);
            if (hold_c != '0) begin
                hold[ch_idx] <= hold_c - HOLD_W'(1);
                led[ch_idx]  <= 1'b1;
            end else if (draw_hit) begin
                hold[ch_idx] <= HOLD_RELOAD;
                led[ch_idx]  <= 1'b1;
            end else begin
                led[ch_idx]  <= 1'b0;
            end
        end
    end

`ifdef LED_RANDOMISER_STATS_EN
    // Saturating increment so the counter sticks at full scale.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Successful-draw counter; clear wins over a coincident hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count <= '0;
        end else if (stats_clr) begin
            hit_count <= '0;
        end else if (enable && scan_en && (hold_c == '0) && draw_hit) begin
            hit_count <= sat_inc16(hit_count);
        end
    end
`endif

endmodule

// File: tb/tb_led_randomiser_array.sv
// Self-checking bench for led_randomiser_array: two instances (hold 1 and
// hold 3) share stimulus and are compared every cycle against a per-draw model.
module tb_led_randomiser_array;

    localparam int N  = 10;
    localparam int PW = 7;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic            tick;
    logic [N*PW-1:0] probability;
    logic [N-1:0]    led_a, led_b;
    logic            busy_a, busy_b;
`ifdef LED_RANDOMISER_STATS_EN
    logic            stats_clr = 1'b0;
    logic [15:0]     hit_a, hit_b;
`endif

    int nasserts = 0;
    int nfail    = 0;

    int       prob [N];
    int       mlfsr;
    bit [N-1:0] mled [2];
    int       mhold [2][N];
    int       holdp [2] = '{1, 3};

    led_randomiser_array #(.NUM_LEDS(N), .PROB_WIDTH(PW), .LFSR_WIDTH(16),
                           .SEED(16'h0001), .HOLD_TICKS(1)) u_a (
        .clk(clk), .rst(rst), .enable(enable), .tick(tick),
        .probability(probability),
`ifdef LED_RANDOMISER_STATS_EN
        .stats_clr(stats_clr), .hit_count(hit_a),
`endif
        .led(led_a), .busy(busy_a));

    led_randomiser_array #(.NUM_LEDS(N), .PROB_WIDTH(PW), .LFSR_WIDTH(16),
                           .SEED(16'h0001), .HOLD_TICKS(3)) u_b (
        .clk(clk), .rst(rst), .enable(enable), .tick(tick),
        .probability(probability),
`ifdef LED_RANDOMISER_STATS_EN
        .stats_clr(stats_clr), .hit_count(hit_b),
`endif
        .led(led_b), .busy(busy_b));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nasserts++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_prob();
        for (int i = 0; i < N; i++) probability[i*PW +: PW] = PW'(prob[i]);
    endtask

    task automatic set_all_prob(input int p);
        for (int i = 0; i < N; i++) prob[i] = p;
        apply_prob();
    endtask

    task automatic model_reset();
        mlfsr = 1;
        for (int d = 0; d < 2; d++) begin
            mled[d] = '0;
            for (int i = 0; i < N; i++) mhold[d][i] = 0;
        end
    endtask

    task automatic model_disable();
        for (int d = 0; d < 2; d++) begin
            mled[d] = '0;
            for (int i = 0; i < N; i++) mhold[d][i] = 0;
        end
    endtask

    // One draw for channel i using the current random value, then advance it.
    task automatic model_chan(input int i);
        int r;
        r = mlfsr;
        for (int d = 0; d < 2; d++) begin
            if (mhold[d][i] > 0) begin
                mhold[d][i]--;
                mled[d][i] = 1'b1;
            end else if (prob[i] != 0 && (r % prob[i]) == 0) begin
                mled[d][i]  = 1'b1;
                mhold[d][i] = holdp[d] - 1;
            end else begin
                mled[d][i] = 1'b0;
            end
        end
        mlfsr = (r % 2 == 1) ? ((r / 2) ^ 32'hB400) : (r / 2);
    endtask

    task automatic check_leds(input string tag);
        check({tag, "_led_a"}, 32'(led_a), 32'(mled[0]));
        check({tag, "_led_b"}, 32'(led_b), 32'(mled[1]));
    endtask

    // Full scan from IDLE; stray ticks inside the scan must be ignored.
    task automatic do_scan(output bit [N-1:0] fa, output bit [N-1:0] fb);
        int gap;
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("busy_start_a", 32'(busy_a), 32'd1);
        check("busy_start_b", 32'(busy_b), 32'd1);
        for (int i = 0; i < N; i++) begin
            tick = ($urandom_range(0, 3) == 0);
            step();
            model_chan(i);
            check_leds("scan");
            check("busy_scan", 32'(busy_a), 32'(i != N - 1));
        end
        tick = 1'b0;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
            step();
            check_leds("idle");
            check("busy_idle", 32'(busy_a), 32'd0);
        end
        fa = led_a;
        fb = led_b;
    endtask

    // Scan aborted by enable going low after k channels have been evaluated.
    task automatic abort_scan(input int k);
        tick = 1'b1;
        step();
        tick = 1'b0;
        for (int i = 0; i < k; i++) begin
            step();
            model_chan(i);
            check_leds("pre_abort");
        end
        enable = 1'b0;
        step();
        model_disable();
        check("abort_led_a", 32'(led_a), 32'd0);
        check("abort_led_b", 32'(led_b), 32'd0);
        check("abort_busy_a", 32'(busy_a), 32'd0);
        check("abort_busy_b", 32'(busy_b), 32'd0);
        enable = 1'b1;
        step();
        check("reenable_no_scan", 32'(busy_a), 32'd0);
    endtask

    initial begin
        bit [N-1:0] fa, fb, lit_a, lit_b;
        bit [N-1:0] ha [4];
        bit [N-1:0] hb [4];
        int cnt0, cnt1;

        rst = 1'b1; enable = 1'b0; tick = 1'b0;
        set_all_prob(0);
        model_reset();
        repeat (2) step();
        check("reset_led_a", 32'(led_a), 32'd0);
        check("reset_led_b", 32'(led_b), 32'd0);
        check("reset_busy_a", 32'(busy_a), 32'd0);
        check("reset_busy_b", 32'(busy_b), 32'd0);
        enable = 1'b1; tick = 1'b1;
        step();
        check("reset_holds_idle", 32'(busy_a), 32'd0);
        tick = 1'b0;
        rst = 1'b0;
        step();

        // p=1 everywhere: LEDs light one per cycle, all on at the end.
        set_all_prob(1);
        do_scan(fa, fb);
        check("p1_all_on_a", 32'(fa), 32'h3FF);
        check("p1_all_on_b", 32'(fb), 32'h3FF);

        // p=0 everywhere: never lit (hold-3 instance drains its holds first).
        set_all_prob(0);
        lit_a = '0; lit_b = '0;
        for (int k = 0; k < 500; k++) begin
            do_scan(fa, fb);
            lit_a |= fa;
            if (k >= 2) lit_b |= fb;
        end
        check("p0_never_lit_a", 32'(lit_a), 32'd0);
        check("p0_never_lit_b", 32'(lit_b), 32'd0);

        // One p=1 tick then p=0: hold-3 LEDs stay lit exactly three ticks.
        set_all_prob(1);
        do_scan(ha[0], hb[0]);
        set_all_prob(0);
        for (int k = 1; k < 4; k++) do_scan(ha[k], hb[k]);
        check("hold3_t0", 32'(hb[0]), 32'h3FF);
        check("hold3_t1", 32'(hb[1]), 32'h3FF);
        check("hold3_t2", 32'(hb[2]), 32'h3FF);
        check("hold3_t3", 32'(hb[3]), 32'h000);
        check("hold1_t0", 32'(ha[0]), 32'h3FF);
        check("hold1_t1", 32'(ha[1]), 32'h000);

        // Enable dropped after three channels, then restart from channel 0.
        set_all_prob(1);
        abort_scan(3);
        do_scan(fa, fb);
        check("restart_all_on", 32'(fa), 32'h3FF);
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < N; i++) prob[i] = $urandom_range(0, 6);
            apply_prob();
            if ($urandom_range(0, 1) == 1) abort_scan($urandom_range(0, N - 1));
            else do_scan(fa, fb);
        end

        // Asynchronous reset between clock edges mid-scan.
        set_all_prob(1);
        tick = 1'b1;
        step();
        tick = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            model_chan(i);
            check_leds("pre_rst");
        end
        #2 rst = 1'b1;
        #1;
        check("async_rst_led_a", 32'(led_a), 32'd0);
        check("async_rst_led_b", 32'(led_b), 32'd0);
        check("async_rst_busy", 32'(busy_a), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        step();
        check_leds("post_rst");

        // Lit fraction for p=15 and p=3 over 3000 ticks.
        for (int i = 0; i < N; i++) prob[i] = $urandom_range(0, 127);
        prob[0] = 15;
        prob[1] = 3;
        apply_prob();
        cnt0 = 0; cnt1 = 0;
        for (int k = 0; k < 3000; k++) begin
            do_scan(fa, fb);
            cnt0 += int'(fa[0]);
            cnt1 += int'(fa[1]);
        end
        check("frac_p15", 32'(cnt0 * 10000 >= 517 * 3000 && cnt0 * 10000 <= 817 * 3000), 32'd1);
        check("frac_p3", 32'(cnt1 * 10000 >= 3083 * 3000 && cnt1 * 10000 <= 3583 * 3000), 32'd1);

        // Randomised probabilities, refreshed every tick.
        for (int k = 0; k < 100; k++) begin
            for (int i = 0; i < N; i++) prob[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4) : $urandom_range(0, 127);
            apply_prob();
            do_scan(fa, fb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nasserts, nfail);
        $finish;
    end

endmodule
